apb_master: RTL

// - APB requester stage that drives the APB slave's p_sel/p_enable/p_add/p_write/p_wdata bus from a simple command port.
// - Sequences each command through IDLE -> SETUP -> ACCESS and waits for p_ready.
// - Returns p_rdata and p_slverr on a one-cycle response strobe.
// - Replaces hand-driven bus tasks; sits between a CPU/DMA-side command source and the slave.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master_if.sv | 53 +++++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_master.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB requester slice.
// - APB_ADDR_W / APB_DATA_W : default address and data widths
// - state_t                 : 2-bit requester state code; 2'b11 is the illegal code
// - ST_IDLE/ST_SETUP/ST_ACCESS : legal state encodings, also visible on the ns port
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_SETUP  = 2'b01;
    localparam state_t ST_ACCESS = 2'b10;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if
// Bundles the command port, the response port and the APB bus of the requester.
// Ports: none, the bundle is purely signals.
// - command : cmd_valid, cmd_ready, cmd_addr, cmd_write, cmd_wdata
// - response: rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
// - APB     : p_add, p_sel, p_enable, p_write, p_wdata, p_rdata, p_ready, p_slverr
// Modports:
// - master : the requester view (drives cmd_ready, rsp_*, and the APB request side)
// - slave  : the surrounding view (command source plus APB completer)
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] p_add;
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_ready;
    logic              p_slverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  p_rdata, p_ready, p_slverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output p_add, p_sel, p_enable, p_write, p_wdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output p_rdata, p_ready, p_slverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  p_add, p_sel, p_enable, p_write, p_wdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
// Counts ACCESS cycles spent waiting on p_ready and flags the cycle whose
// increment reaches TIMEOUT.
// Ports:
// - p_clk   in  clock
// - p_reset in  synchronous active-high reset
// - clear   in  zero the count (asserted while entering ACCESS)
// - inc     in  one more wait cycle at this edge
// - expired out this edge's increment brings the count to TIMEOUT
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic p_clk,
    input  logic p_reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge p_clk) begin
        if (p_reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // Looking one step ahead lets the FSM abort on the very edge the count hits TIMEOUT.
    assign expired = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// apb_master
// APB requester: accepts a command, walks it through SETUP and ACCESS on the
// APB bus, waits for p_ready (bounded by TIMEOUT) and returns a one-cycle
// response strobe. Every output is a register.
// Ports:
// - p_clk   in   clock, rising edge
// - p_reset in   synchronous active-high reset
// - bus     master modport of apb_master_if (command, response and APB signals)
// - ns      out  current state: 00 IDLE, 01 SETUP, 10 ACCESS
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic         p_clk,
    input  logic         p_reset,
    apb_master_if.master bus,
    output logic [1:0]   ns
);

    state_t state;
    state_t state_next;

    logic accept;
    logic timer_clear;
    logic timer_inc;
    logic timer_expired;

    logic [ADDR_W-1:0] p_add_n;
    logic              p_sel_n;
    logic              p_enable_n;
    logic              p_write_n;
    logic [DATA_W-1:0] p_wdata_n;
    logic              cmd_ready_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              rsp_slverr_n;
    logic              rsp_timeout_n;

    assign accept      = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign timer_clear = (state == ST_SETUP);
    assign timer_inc   = (state == ST_ACCESS) && !bus.p_ready;
    assign ns          = state;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // State and all output registers; reset zeroes everything and drops any transfer.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state           <= ST_IDLE;
            bus.cmd_ready   <= 1'b0;
            bus.p_add       <= '0;
            bus.p_sel       <= 1'b0;
            bus.p_enable    <= 1'b0;
            bus.p_write     <= 1'b0;
            bus.p_wdata     <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_slverr  <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            state           <= state_next;
            bus.cmd_ready   <= cmd_ready_n;
            bus.p_add       <= p_add_n;
            bus.p_sel       <= p_sel_n;
            bus.p_enable    <= p_enable_n;
            bus.p_write     <= p_write_n;
            bus.p_wdata     <= p_wdata_n;
            bus.rsp_valid   <= rsp_valid_n;
            bus.rsp_rdata   <= rsp_rdata_n;
            bus.rsp_slverr  <= rsp_slverr_n;
            bus.rsp_timeout <= rsp_timeout_n;
        end
    end

    // Next state: SETUP is always one cycle; ACCESS ends on p_ready or on timer expiry.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (bus.p_ready || timer_expired) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Next output values. Address/direction/data and response fields hold by
    // default so they stay stable after a transfer; the illegal code clears them.
    always_comb begin
        p_add_n       = bus.p_add;
        p_sel_n       = bus.p_sel;
        p_enable_n    = bus.p_enable;
        p_write_n     = bus.p_write;
        p_wdata_n     = bus.p_wdata;
        rsp_valid_n   = 1'b0;
        rsp_rdata_n   = bus.rsp_rdata;
        rsp_slverr_n  = bus.rsp_slverr;
        rsp_timeout_n = bus.rsp_timeout;
        cmd_ready_n   = (state_next == ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    p_add_n    = bus.cmd_addr;
                    p_write_n  = bus.cmd_write;
                    p_wdata_n  = bus.cmd_write ? bus.cmd_wdata : '0;
                    p_sel_n    = 1'b1;
                    p_enable_n = 1'b0;
                end
            end
            ST_SETUP: begin
                p_enable_n = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.p_ready) begin
                    p_sel_n       = 1'b0;
                    p_enable_n    = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = bus.p_write ? '0 : bus.p_rdata;
                    rsp_slverr_n  = bus.p_slverr;
                    rsp_timeout_n = 1'b0;
                end else if (timer_expired) begin
                    p_sel_n       = 1'b0;
                    p_enable_n    = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = '0;
                    rsp_slverr_n  = 1'b1;
                    rsp_timeout_n = 1'b1;
                end
            end
            default: begin
                p_add_n       = '0;
                p_sel_n       = 1'b0;
                p_enable_n    = 1'b0;
                p_write_n     = 1'b0;
                p_wdata_n     = '0;
                rsp_rdata_n   = '0;
                rsp_slverr_n  = 1'b0;
                rsp_timeout_n = 1'b0;
            end
        endcase
    end

endmodule
